image_spike_encoder: RTL
========================

// Module: image_spike_encoder
// PURPOSE
//  Consumes the pixel array and NEW_IMAGE level from the AXI4-Lite slave interface and converts
//  the image into rate-coded spike events for the SNN core. Per timestep it scans all pixels with
//  a per-pixel phase accumulator, emits one AER event per spiking pixel, then emits a
//  timestep-end marker. After N_TIMESTEPS timesteps it pulses DONE and returns to idle.
// PARAMETERS
//  IMAGE_SIZE       256  number of pixels
//  IMAGE_SIZE_BITS  8    $clog2(IMAGE_SIZE), pixel address width
//  PIXEL_BITS       8    pixel/accumulator width
//  N_TIMESTEPS      16   timesteps per inference (>=1)
//  TS_BITS          4    $clog2(N_TIMESTEPS), timestep counter width (min 1)
// PORTS
//  CLK           in   1                     clock, all logic on rising edge
//  RST           in   1                     synchronous reset, active-high
//  IMAGE         in   [PIXEL_BITS-1:0] x IMAGE_SIZE  pixel array from AXI interface
//  NEW_IMAGE     in   1                     level from AXI interface; rising edge starts encoding
//  AEROUT_ADDR   out  IMAGE_SIZE_BITS       spiking pixel index (0 when AEROUT_TREF=1)
//  AEROUT_TREF   out  1                     1 = timestep-end marker, 0 = spike event
//  AEROUT_VALID  out  1                     event valid
//  AEROUT_READY  in   1                     SNN core accepts event
//  BUSY          out  1                     encoding in progress
//  DONE          out  1                     one-cycle pulse after final marker accepted
// BEHAVIOUR
//  - Reset (RST=1 at edge): state IDLE; AEROUT_VALID/TREF/ADDR=0, BUSY=0, DONE=0; accumulators,
//    pixel and timestep counters =0; NEW_IMAGE edge register =0. Reset mid-operation aborts
//    immediately; no further event issued, a pending event is dropped.
//  - Start: rising edge = NEW_IMAGE & ~new_image_q. In IDLE at edge cycle k: latch IMAGE into
//    local copy, clear all accumulators, pix=0, ts=0; BUSY=1 from k+1. Edges while BUSY ignored
//    (local copy unchanged). IMAGE changes after latch have no effect.
//  - States: IDLE -> SCAN -> (EMIT) -> ... -> TREF -> SCAN | FINISH -> IDLE.
//  - SCAN (one pixel/cycle): sum = acc[pix] + img[pix] (PIXEL_BITS+1 bits);
//    acc[pix] <= sum[PIXEL_BITS-1:0]; spike = sum[PIXEL_BITS].
//    spike=1 -> EMIT with ADDR=pix, VALID=1 next cycle. spike=0 -> pix++ (stay SCAN),
//    or TREF if pix==IMAGE_SIZE-1.
//  - EMIT/TREF handshake: VALID, ADDR, TREF held stable until VALID&READY at an edge; READY may
//    already be high the cycle VALID rises (transfer that edge). VALID never drops without
//    transfer. After EMIT transfer: pix++ -> SCAN, or -> TREF if pix was IMAGE_SIZE-1.
//  - TREF: VALID=1, TREF=1, ADDR=0. On transfer: if ts==N_TIMESTEPS-1 -> FINISH, else ts++,
//    pix=0 -> SCAN.
//  - FINISH: DONE=1 for exactly one cycle, BUSY=0 in that same cycle; -> IDLE. New edge accepted
//    from the following cycle.
//  - Spike count: pixel value p spikes exactly floor(p*N_TIMESTEPS/2^PIXEL_BITS) times per
//    inference; p=0 never spikes. Events in a timestep are in ascending address order.
//  - Minimum cycles (READY always 1): N_TIMESTEPS*(IMAGE_SIZE+1+spikes_per_ts)+1.
// TESTING
//  1 All-zero image, NEW_IMAGE 0->1, READY=1 -> exactly 16 TREF markers, 0 spikes, DONE once,
//    BUSY low with DONE.
//  2 IMAGE[5]=128, IMAGE[200]=255, rest 0 -> addr 5 x8, addr 200 x15, 16 markers; in-timestep
//    order 5 before 200; ts 0: no events, only marker.
//  3 Sample image from the AXI bench (pixels 3..244) -> per-pixel counts equal
//    floor(p*16/256) vs. reference model; total markers 16.
//  4 Random READY toggling (~50%) on case 2 -> ADDR/TREF stable while VALID&~READY; identical
//    event sequence to case 2.
//  5 Second NEW_IMAGE edge and IMAGE change mid-encoding -> ignored; output matches
//    first image; edge after DONE starts a new run.
//  6 RST=1 for 1 cycle during timestep 7 with VALID=1 -> next cycle all outputs 0, IDLE; a new
//    edge restarts from ts=0 with cleared accumulators.

Source files
------------

// File: rtl/image_spike_encoder.sv
// image_spike_encoder: rate-codes a latched pixel array into AER spike events.
// Each timestep walks every pixel once, adding the pixel value into its phase
// accumulator; an accumulator carry-out emits one event for that pixel. A
// timestep-end marker closes each timestep, and DONE pulses after the last one.
module image_spike_encoder #(
  parameter int IMAGE_SIZE      = 256,
  parameter int IMAGE_SIZE_BITS = 8,
  parameter int PIXEL_BITS      = 8,
  parameter int N_TIMESTEPS     = 16,
  parameter int TS_BITS         = 4
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
  input  logic                                 NEW_IMAGE,
  output logic [IMAGE_SIZE_BITS-1:0]           AEROUT_ADDR,
  output logic                                 AEROUT_TREF,
  output logic                                 AEROUT_VALID,
  input  logic                                 AEROUT_READY,
  output logic                                 BUSY,
  output logic                                 DONE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_EMIT   = 3'd2,
    S_TREF   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [IMAGE_SIZE_BITS-1:0] LAST_PIX = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
  localparam logic [TS_BITS-1:0]         LAST_TS  = TS_BITS'(N_TIMESTEPS - 1);

  state_t                     state_q, state_d;
  logic                       new_image_q;
  logic [PIXEL_BITS-1:0]      img_q [IMAGE_SIZE];
  logic [PIXEL_BITS-1:0]      acc_q [IMAGE_SIZE];
  logic [IMAGE_SIZE_BITS-1:0] pix_q;
  logic [TS_BITS-1:0]         ts_q;

  logic [IMAGE_SIZE_BITS-1:0] addr_d;
  logic                       tref_d, valid_d, busy_d, done_d;

  logic                       start_s;
  logic                       xfer_s;
  logic                       last_pix_s;
  logic                       last_ts_s;
  logic [PIXEL_BITS:0]        sum_s;
  logic                       spike_s;

  // Start only on a fresh rising edge; outputs drive the handshake directly.
  assign start_s    = NEW_IMAGE & ~new_image_q;
  assign xfer_s     = AEROUT_VALID & AEROUT_READY;
  assign last_pix_s = (pix_q == LAST_PIX);
  assign last_ts_s  = (ts_q == LAST_TS);
  assign sum_s      = {1'b0, acc_q[pix_q]} + {1'b0, img_q[pix_q]};
  assign spike_s    = sum_s[PIXEL_BITS];

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: scan pixels, hold events until accepted, close timesteps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (spike_s) begin
          state_d = S_EMIT;
        end else if (last_pix_s) begin
          state_d = S_TREF;
        end else begin
          state_d = S_SCAN;
        end
      end
      S_EMIT: begin
        if (xfer_s) begin
          state_d = last_pix_s ? S_TREF : S_SCAN;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_TREF: begin
        if (xfer_s) begin
          state_d = last_ts_s ? S_FINISH : S_SCAN;
        end else begin
          state_d = S_TREF;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    valid_d = 1'b0;
    tref_d  = 1'b0;
    addr_d  = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_IDLE:   busy_d = 1'b0;
      S_SCAN:   busy_d = 1'b1;
      S_EMIT: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        addr_d  = pix_q;
      end
      S_TREF: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        tref_d  = 1'b1;
      end
      S_FINISH: done_d = 1'b1;
      default:  busy_d = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      AEROUT_VALID <= 1'b0;
      AEROUT_TREF  <= 1'b0;
      AEROUT_ADDR  <= '0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      AEROUT_VALID <= valid_d;
      AEROUT_TREF  <= tref_d;
      AEROUT_ADDR  <= addr_d;
      BUSY         <= busy_d;
      DONE         <= done_d;
    end
  end

  // NEW_IMAGE history for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      new_image_q <= 1'b0;
    end else begin
      new_image_q <= NEW_IMAGE;
    end
  end

  // Pixel and timestep counters; pix holds on a spiking pixel until its event is accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pix_q <= '0;
      ts_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            pix_q <= '0;
            ts_q  <= '0;
          end
        end
        S_SCAN: begin
          if (!spike_s && !last_pix_s) begin
            pix_q <= pix_q + IMAGE_SIZE_BITS'(1);
          end
        end
        S_EMIT: begin
          if (xfer_s && !last_pix_s) begin
            pix_q <= pix_q + IMAGE_SIZE_BITS'(1);
          end
        end
        S_TREF: begin
          if (xfer_s && !last_ts_s) begin
            ts_q  <= ts_q + TS_BITS'(1);
            pix_q <= '0;
          end
        end
        default: begin
          pix_q <= pix_q;
        end
      endcase
    end
  end

  // Image snapshot and phase accumulators; the snapshot only changes on an accepted start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        acc_q[i] <= '0;
        img_q[i] <= '0;
      end
    end else if (state_q == S_IDLE && start_s) begin
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        acc_q[i] <= '0;
        img_q[i] <= IMAGE[i];
      end
    end else if (state_q == S_SCAN) begin
      acc_q[pix_q] <= sum_s[PIXEL_BITS-1:0];
    end
  end

endmodule
